eoc_readout_responder: RTL and testbench

End-of-column (EOC) readout responder. It is the EOC-side counterpart of the control unit's request/token/read protocol.
- Buffers pixel hit words from its double column in a small FIFO.
- On a readout request, freezes a snapshot of its occupancy and raises a flag onto the daisy-chained token.
- When it holds priority, it drives its words onto the shared wired-OR data bus, one word per read strobe.
- One instance per double column, chained from highest to lowest priority; the last eoc_token_o feeds the control unit.

---
 rtl/eoc_readout_responder.sv | 130 +++++++++++++
 tb/tb_eoc_readout_responder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/eoc_readout_responder.sv
// rtl/eoc_readout_responder.sv - end-of-column hit buffer with request/token/read responder
//
// Purpose:
//   Buffers pixel hit words from one double column in a show-ahead FIFO.
//   A readout request snapshots the FIFO occupancy into frame_cnt. While
//   frame_cnt is non-zero the EOC raises its flag onto the daisy-chained
//   token. It owns the shared wired-OR bus when its flag is up and no
//   higher-priority neighbour holds the token. Each read strobe pops one
//   word while it owns the bus.
//
// Ports:
//   clk40MHz_i     40 MHz clock
//   rst_i          asynchronous reset, active high
//   hit_valid_i    push strobe from the double column
//   hit_data_i     hit word
//   eoc_rqt_data_i readout request pulse from the control unit
//   eoc_rd_i       read strobe from the control unit
//   eoc_token_i    token from the higher-priority neighbour
//   eoc_token_o    token to the lower-priority neighbour
//   eoc_data_o     {COL_ID, head word} when owner, else zero
//   eoc_data_oe_o  high while this EOC owns the bus
//   fifo_full_o    FIFO occupancy equals DEPTH
//   overflow_o     sticky hit-drop indicator, cleared by a request
module eoc_readout_responder #(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 8,
  parameter int COL_ID_W = 5,
  parameter int COL_ID   = 0
) (
  input  logic                       clk40MHz_i,
  input  logic                       rst_i,
  input  logic                       hit_valid_i,
  input  logic [DATA_W-1:0]          hit_data_i,
  input  logic                       eoc_rqt_data_i,
  input  logic                       eoc_rd_i,
  input  logic                       eoc_token_i,
  output logic                       eoc_token_o,
  output logic [COL_ID_W+DATA_W-1:0] eoc_data_o,
  output logic                       eoc_data_oe_o,
  output logic                       fifo_full_o,
  output logic                       overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]         FULL_OCC = (AW+1)'(DEPTH);
  localparam logic [COL_ID_W-1:0] COL_ID_C = COL_ID_W'(COL_ID);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       occ_q, occ_d;
  logic [AW:0]       frame_cnt_q, frame_cnt_d;
  logic              overflow_q, overflow_d;

  logic flag;
  logic owner;
  logic rd_acc;
  logic pop;
  logic push;
  logic drop;

  always_comb begin
    flag   = (frame_cnt_q != '0);
    owner  = flag & ~eoc_token_i;
    // A read strobe is only meaningful to the EOC currently owning the bus.
    rd_acc = eoc_rd_i & owner;
    pop    = rd_acc & (occ_q != '0);
    // A push at full is allowed only when a pop frees a slot in the same cycle.
    push   = hit_valid_i & ((occ_q != FULL_OCC) | pop);
    drop   = hit_valid_i & ~push;

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase

    // The snapshot uses pre-cycle occupancy: hits arriving in the request
    // cycle belong to the next frame, and a concurrent pop is not counted.
    frame_cnt_d = frame_cnt_q;
    if (eoc_rqt_data_i) begin
      frame_cnt_d = occ_q;
    end else if (rd_acc) begin
      frame_cnt_d = frame_cnt_q - 1'b1;
    end

    // A drop in the request cycle wins over the clear.
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (eoc_rqt_data_i) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk40MHz_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      frame_cnt_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      frame_cnt_q <= frame_cnt_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage needs no reset: occupancy and pointers define what is valid.
  always_ff @(posedge clk40MHz_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= hit_data_i;
    end
  end

  // Token is combinational so the whole chain settles within one cycle.
  assign eoc_token_o   = eoc_token_i | flag;
  assign eoc_data_oe_o = owner;
  assign eoc_data_o    = owner ? {COL_ID_C, mem_q[rd_ptr_q]} : '0;
  assign fifo_full_o   = (occ_q == FULL_OCC);
  assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_eoc_readout_responder.sv
// tb/tb_eoc_readout_responder.sv - two-EOC chain bench with queue-based reference model
module tb_eoc_readout_responder;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int CW    = 5;
  localparam int BW    = CW + DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          hv0, hv1;
  logic [DW-1:0] hd0, hd1;
  logic          rqt, rd, tin;
  logic          t0, t1;
  logic [BW-1:0] d0, d1;
  logic          oe0, oe1, full0, full1, ov0, ov1;

  int checks = 0;
  int errors = 0;

  // Reference model: one queue of buffered words, a frame count and an
  // overflow flag per column.
  logic [DW-1:0] q[2][$];
  int            fc[2];
  bit            mov[2];

  eoc_readout_responder #(.DATA_W(DW), .DEPTH(DEPTH), .COL_ID_W(CW), .COL_ID(1)) u_eoc0 (
    .clk40MHz_i    (clk),
    .rst_i         (rst),
    .hit_valid_i   (hv0),
    .hit_data_i    (hd0),
    .eoc_rqt_data_i(rqt),
    .eoc_rd_i      (rd),
    .eoc_token_i   (tin),
    .eoc_token_o   (t0),
    .eoc_data_o    (d0),
    .eoc_data_oe_o (oe0),
    .fifo_full_o   (full0),
    .overflow_o    (ov0)
  );

  eoc_readout_responder #(.DATA_W(DW), .DEPTH(DEPTH), .COL_ID_W(CW), .COL_ID(2)) u_eoc1 (
    .clk40MHz_i    (clk),
    .rst_i         (rst),
    .hit_valid_i   (hv1),
    .hit_data_i    (hd1),
    .eoc_rqt_data_i(rqt),
    .eoc_rd_i      (rd),
    .eoc_token_i   (t0),
    .eoc_token_o   (t1),
    .eoc_data_o    (d1),
    .eoc_data_oe_o (oe1),
    .fifo_full_o   (full1),
    .overflow_o    (ov1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      q[k].delete();
      fc[k]  = 0;
      mov[k] = 1'b0;
    end
  endtask

  task automatic check_outputs();
    bit f0, f1, et0, et1, o0, o1;
    logic [BW-1:0] e0, e1;
    f0  = (fc[0] != 0);
    f1  = (fc[1] != 0);
    et0 = tin | f0;
    o0  = f0 & !tin;
    et1 = et0 | f1;
    o1  = f1 & !et0;
    e0  = (o0 && q[0].size() > 0) ? {CW'(1), q[0][0]} : '0;
    e1  = (o1 && q[1].size() > 0) ? {CW'(2), q[1][0]} : '0;
    check("token0", 32'(t0), 32'(et0));
    check("token1", 32'(t1), 32'(et1));
    check("oe0", 32'(oe0), 32'(o0));
    check("oe1", 32'(oe1), 32'(o1));
    check("data0", 32'(d0), 32'(e0));
    check("data1", 32'(d1), 32'(e1));
    check("full0", 32'(full0), 32'(q[0].size() == DEPTH));
    check("full1", 32'(full1), 32'(q[1].size() == DEPTH));
    check("ovf0", 32'(ov0), 32'(mov[0]));
    check("ovf1", 32'(ov1), 32'(mov[1]));
  endtask

  task automatic model_edge();
    bit own[2];
    bit hv_a[2];
    logic [DW-1:0] hd_a[2];
    bit pop, push, drop;
    hv_a[0] = hv0;
    hv_a[1] = hv1;
    hd_a[0] = hd0;
    hd_a[1] = hd1;
    own[0] = (fc[0] != 0) && !tin;
    own[1] = (fc[1] != 0) && !(tin || (fc[0] != 0));
    for (int k = 0; k < 2; k++) begin
      pop  = rd && own[k];
      push = hv_a[k] && (q[k].size() < DEPTH || pop);
      drop = hv_a[k] && !push;
      if (rqt) fc[k] = q[k].size();
      else if (pop) fc[k]--;
      if (pop) void'(q[k].pop_front());
      if (push) q[k].push_back(hd_a[k]);
      if (drop) mov[k] = 1'b1;
      else if (rqt) mov[k] = 1'b0;
    end
  endtask

  // Inputs are applied just after a rising edge, outputs checked on the
  // falling edge, and the model advanced at the next rising edge.
  task automatic cycle(input bit v0, input bit v1, input bit r, input bit rdv, input bit ti);
    hv0 = v0;
    hv1 = v1;
    hd0 = 16'($urandom);
    hd1 = 16'($urandom);
    rqt = r;
    rd  = rdv;
    tin = ti;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    hv0 = 0; hv1 = 0; hd0 = '0; hd1 = '0; rqt = 0; rd = 0; tin = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_outputs();

    // Single column: three words, one request, three reads.
    repeat (3) cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    repeat (3) cycle(0, 0, 0, 1, 0);
    repeat (2) cycle(0, 0, 0, 0, 0);

    // Two-column chain, two words each.
    repeat (2) cycle(1, 1, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    repeat (4) cycle(0, 0, 0, 1, 0);
    repeat (2) cycle(0, 0, 0, 0, 0);

    // Overflow: nine pushes into a depth-eight FIFO, then drain.
    repeat (9) cycle(1, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    repeat (16) cycle(0, 0, 0, 1, 0);
    repeat (2) cycle(0, 0, 0, 0, 0);

    // Hit arriving mid-frame joins the next frame only.
    repeat (2) cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(1, 0, 0, 1, 0);
    repeat (2) cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 1, 0, 0);
    repeat (2) cycle(0, 0, 0, 1, 0);

    // Reads without ownership, request on empty FIFOs, forced upstream token.
    repeat (2) cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 1, 0, 0);
    repeat (2) cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 0);

    // Asynchronous reset in the middle of a frame.
    repeat (4) cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 1, 0);
    hv0 = 0; hv1 = 0; rqt = 0; rd = 0; tin = 0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(0, 0, 1, 0, 0);
    repeat (2) cycle(0, 0, 0, 1, 0);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      bit v0, v1, r, rdv, ti;
      v0  = ($urandom_range(0, 9) < 4);
      v1  = ($urandom_range(0, 9) < 4);
      r   = ($urandom_range(0, 15) == 0);
      rdv = !r && ($urandom_range(0, 1) == 1);
      ti  = ($urandom_range(0, 19) == 0);
      cycle(v0, v1, r, rdv, ti);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
